// File: rtl/paddle_mover.sv
// paddle_mover: self-moving paddle sprite for the VGA pong datapath.
// Follows the beam with local column/row counters, draws a fixed-size
// rectangle at column p_XPOS and moves it vertically once per frame from
// debounced up/down levels, switching to a faster step after a long hold.
module paddle_mover #(
  parameter int p_XPOS         = 40,
  parameter int p_WIDTH        = 10,
  parameter int p_HEIGHT       = 50,
  parameter int p_INIT_Y       = 215,
  parameter int p_STEP         = 2,
  parameter int p_FAST_STEP    = 6,
  parameter int p_ACCEL_FRAMES = 8,
  parameter int p_H_VISIBLE    = 640,
  parameter int p_V_VISIBLE    = 480
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_Enabled,
  input  logic       i_Up,
  input  logic       i_Down,
  output logic       o_Video,
  output logic [9:0] o_YPos,
  output logic       o_Fast
);

  // Horizontal extent is fixed; the paddle never leaves its column band.
  localparam logic [10:0] c_X_LO     = 11'(p_XPOS);
  localparam logic [10:0] c_X_HI     = 11'(p_XPOS + p_WIDTH);
  localparam logic [10:0] c_HEIGHT   = 11'(p_HEIGHT);
  localparam logic [10:0] c_Y_MAX    = 11'(p_V_VISIBLE - p_HEIGHT);
  localparam logic [9:0]  c_INIT_Y   = 10'(p_INIT_Y);
  localparam logic [9:0]  c_STEP     = 10'(p_STEP);
  localparam logic [9:0]  c_FAST     = 10'(p_FAST_STEP);
  localparam logic [9:0]  c_CNT_MAX  = 10'd1023;
  localparam logic [7:0]  c_HOLD_MAX = 8'(p_ACCEL_FRAMES);
  localparam logic [8:0]  c_ACCEL    = 9'(p_ACCEL_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_SLOW = 2'd1,
    MOVE_FAST = 2'd2
  } state_t;

  logic [9:0] col_r;
  logic [9:0] row_r;
  logic [9:0] y_r;
  logic [7:0] hold_r;
  logic       dir_up_r;
  state_t     state_r;

  state_t     state_s;
  logic [9:0] y_s;
  logic [7:0] hold_s;
  logic       dir_up_s;
  logic       up_s;
  logic       down_s;
  logic       in_x_s;
  logic       in_y_s;

  // One clamped step: 11-bit arithmetic so neither direction can wrap.
  function automatic logic [9:0] move_y(input logic [9:0] y,
                                        input logic       up,
                                        input logic [9:0] step);
    logic [10:0] y_w;
    logic [10:0] s_w;
    logic [10:0] sum_w;
    y_w   = {1'b0, y};
    s_w   = {1'b0, step};
    sum_w = y_w + s_w;
    if (up) begin
      if (y_w < s_w) begin
        move_y = 10'd0;
      end else begin
        move_y = 10'(y_w - s_w);
      end
    end else begin
      if (sum_w > c_Y_MAX) begin
        move_y = c_Y_MAX[9:0];
      end else begin
        move_y = sum_w[9:0];
      end
    end
  endfunction

  // Column counter: cleared at line start, counts visible pixels, saturates.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_r <= 10'd0;
    end else if (i_HReset) begin
      col_r <= 10'd0;
    end else if (!i_HBlank && (col_r != c_CNT_MAX)) begin
      col_r <= col_r + 10'd1;
    end
  end

  // Row counter: frame start wins over line start; counts visible lines.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      row_r <= 10'd0;
    end else if (i_VReset) begin
      row_r <= 10'd0;
    end else if (i_HReset && !i_VBlank && (row_r != c_CNT_MAX)) begin
      row_r <= row_r + 10'd1;
    end
  end

  // Movement decision: evaluated only on an enabled frame-start cycle.
  always_comb begin
    state_s  = state_r;
    y_s      = y_r;
    hold_s   = hold_r;
    dir_up_s = dir_up_r;
    up_s     = i_Up & ~i_Down;
    down_s   = i_Down & ~i_Up;
    if (i_VReset && i_Enabled) begin
      case (state_r)
        IDLE: begin
          if (up_s || down_s) begin
            state_s  = MOVE_SLOW;
            hold_s   = 8'd1;
            dir_up_s = up_s;
            y_s      = move_y(y_r, up_s, c_STEP);
          end else begin
            state_s = IDLE;
            hold_s  = 8'd0;
          end
        end
        MOVE_SLOW: begin
          if (!(up_s || down_s)) begin
            state_s = IDLE;
            hold_s  = 8'd0;
          end else if (up_s != dir_up_r) begin
            state_s  = MOVE_SLOW;
            hold_s   = 8'd1;
            dir_up_s = up_s;
            y_s      = move_y(y_r, up_s, c_STEP);
          end else if (({1'b0, hold_r} + 9'd1) >= c_ACCEL) begin
            state_s = MOVE_FAST;
            hold_s  = hold_r + 8'd1;
            y_s     = move_y(y_r, up_s, c_FAST);
          end else begin
            state_s = MOVE_SLOW;
            hold_s  = hold_r + 8'd1;
            y_s     = move_y(y_r, up_s, c_STEP);
          end
        end
        MOVE_FAST: begin
          if (!(up_s || down_s)) begin
            state_s = IDLE;
            hold_s  = 8'd0;
          end else if (up_s != dir_up_r) begin
            state_s  = MOVE_SLOW;
            hold_s   = 8'd1;
            dir_up_s = up_s;
            y_s      = move_y(y_r, up_s, c_STEP);
          end else begin
            state_s = MOVE_FAST;
            hold_s  = (hold_r < c_HOLD_MAX) ? (hold_r + 8'd1) : hold_r;
            y_s     = move_y(y_r, up_s, c_FAST);
          end
        end
        default: begin
          state_s = IDLE;
          hold_s  = 8'd0;
        end
      endcase
    end else begin
      state_s  = state_r;
      y_s      = y_r;
      hold_s   = hold_r;
      dir_up_s = dir_up_r;
    end
  end

  // Movement state, hold counter, direction and paddle position registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r  <= IDLE;
      y_r      <= c_INIT_Y;
      hold_r   <= 8'd0;
      dir_up_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      y_r      <= y_s;
      hold_r   <= hold_s;
      dir_up_r <= dir_up_s;
    end
  end

  // Pixel hit test against the registered beam position and paddle top row.
  always_comb begin
    in_x_s  = ({1'b0, col_r} >= c_X_LO) && ({1'b0, col_r} < c_X_HI);
    in_y_s  = ({1'b0, row_r} >= {1'b0, y_r}) &&
              ({1'b0, row_r} < ({1'b0, y_r} + c_HEIGHT));
    o_Video = i_Enabled & ~i_HBlank & ~i_VBlank & in_x_s & in_y_s;
  end

  assign o_YPos = y_r;
  assign o_Fast = (state_r == MOVE_FAST);

endmodule

// File: tb/tb_paddle_mover.sv
// Bench for paddle_mover: table-driven frame sequence, hand-written corner
// sequences and randomized frames against a run-length reference model.
module tb_paddle_mover;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_HReset = 1'b0;
  logic       i_VReset = 1'b0;
  logic       i_HBlank = 1'b1;
  logic       i_VBlank = 1'b1;
  logic       i_Enabled = 1'b1;
  logic       i_Up = 1'b0;
  logic       i_Down = 1'b0;
  logic       o_Video;
  logic [9:0] o_YPos;
  logic       o_Fast;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: paddle top row plus current run of same-direction frames.
  int m_y   = 215;
  int m_dir = 0;
  int m_len = 0;

  typedef struct {
    bit up;
    bit down;
    bit en;
    int exp_y;
    bit exp_fast;
  } vec_t;
  vec_t tbl[19];

  paddle_mover dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HReset(i_HReset), .i_VReset(i_VReset),
    .i_HBlank(i_HBlank), .i_VBlank(i_VBlank), .i_Enabled(i_Enabled),
    .i_Up(i_Up), .i_Down(i_Down), .o_Video(o_Video), .o_YPos(o_YPos), .o_Fast(o_Fast)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int model_fast();
    return (m_len >= 8) ? 1 : 0;
  endfunction

  // Frame-start update from the behavioural rules.
  task automatic model_frame(input bit up, input bit down, input bit en);
    int d;
    int step;
    if (en) begin
      d = (up && !down) ? -1 : ((down && !up) ? 1 : 0);
      if (d == 0) begin
        m_dir = 0;
        m_len = 0;
      end else begin
        if (d == m_dir) m_len++;
        else begin
          m_dir = d;
          m_len = 1;
        end
        step = (m_len >= 8) ? 6 : 2;
        if (d < 0) m_y = (m_y - step < 0) ? 0 : m_y - step;
        else       m_y = (m_y + step > 430) ? 430 : m_y + step;
      end
    end
  endtask

  task automatic model_reset();
    m_y = 215;
    m_dir = 0;
    m_len = 0;
  endtask

  // One pixel clock: drive, sample video mid-cycle, then step past the edge.
  task automatic cyc(input bit hr, input bit vr, input bit hb, input bit vb, output bit v);
    i_HReset = hr;
    i_VReset = vr;
    i_HBlank = hb;
    i_VBlank = vb;
    @(negedge i_Clk);
    v = o_Video;
    @(posedge i_Clk);
    #1;
  endtask

  // A frame of n_vis visible lines (n_pix visible pixels) plus one blank line.
  // rst_line >= 0 pulses i_Reset on pixel 45 of that line and ends the frame.
  task automatic run_frame(input int n_vis, input int n_pix, input bit up,
                           input bit down, input bit en, input int rst_line);
    bit v;
    bit e;
    bit hb;
    bit vb;
    int px;
    int mism = 0;
    int cnt = 0;
    int ecnt = 0;
    i_Up = up;
    i_Down = down;
    i_Enabled = en;
    model_frame(up, down, en);
    for (int l = 0; l <= n_vis; l++) begin
      vb = (l == n_vis);
      for (int c = 0; c < n_pix + 2; c++) begin
        hb = (c < 2);
        px = c - 2;
        e = en && !hb && !vb && px >= 40 && px < 50 && l >= m_y && l < m_y + 50;
        if (l == rst_line && px == 45) begin
          check("fast_before_reset", int'(o_Fast), model_fast());
          i_Reset = 1'b1;
          cyc(1'b0, 1'b0, hb, vb, v);
          check("video_before_reset", int'(v), int'(e));
          i_Reset = 1'b0;
          model_reset();
          check("reset_mid_ypos", int'(o_YPos), 215);
          check("reset_mid_fast", int'(o_Fast), 0);
          check("reset_mid_video", int'(o_Video), 0);
          return;
        end
        cyc(c == 0, (l == 0) && (c == 0), hb, vb, v);
        if (v) cnt++;
        if (e) ecnt++;
        if (v != e) mism++;
      end
    end
    check("frame_video_mismatch_pixels", mism, 0);
    check("frame_video_count", cnt, ecnt);
    check("frame_ypos", int'(o_YPos), m_y);
    check("frame_fast", int'(o_Fast), model_fast());
  endtask

  initial begin
    bit v;
    int r;
    bit ru;
    bit rd;
    bit ren;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 215, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 213, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 211, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 209, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 207, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 205, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 203, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 201, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 195, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 189, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 183, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 183, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 177, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 179, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 181, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 181, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 183, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 183, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 183, 1'b0};

    // Reset state.
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, v);
    i_Reset = 1'b0;
    i_HBlank = 1'b0;
    i_VBlank = 1'b0;
    #1;
    check("reset_ypos", int'(o_YPos), 215);
    check("reset_fast", int'(o_Fast), 0);
    check("reset_video", int'(o_Video), 0);
    model_reset();

    // Full frame with no input: 500 paddle pixels at y=215.
    run_frame(270, 52, 1'b0, 1'b0, 1'b1, -1);
    check("idle_frame_ypos", int'(o_YPos), 215);

    // Table of short frames: slow/fast up, reversal, both pressed, disable.
    for (int i = 0; i < 19; i++) begin
      run_frame(2, 4, tbl[i].up, tbl[i].down, tbl[i].en, -1);
      check($sformatf("tbl%0d_ypos", i), int'(o_YPos), tbl[i].exp_y);
      check($sformatf("tbl%0d_fast", i), int'(o_Fast), int'(tbl[i].exp_fast));
    end

    // Full frame at the moved position, then accelerate and freeze.
    run_frame(236, 52, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 8; i++) run_frame(2, 4, 1'b1, 1'b0, 1'b1, -1);
    check("accel_ypos", int'(o_YPos), 163);
    check("accel_fast", int'(o_Fast), 1);
    run_frame(236, 52, 1'b1, 1'b0, 1'b0, -1);
    check("disabled_ypos", int'(o_YPos), 163);

    // Reset in the middle of a paddle line while moving fast.
    run_frame(236, 52, 1'b1, 1'b0, 1'b1, 200);

    // Top clamp, then bottom clamp.
    for (int i = 0; i < 45; i++) run_frame(2, 4, 1'b1, 1'b0, 1'b1, -1);
    check("top_clamp_ypos", int'(o_YPos), 0);
    check("top_clamp_fast", int'(o_Fast), 1);
    for (int i = 0; i < 80; i++) run_frame(2, 4, 1'b0, 1'b1, 1'b1, -1);
    check("bottom_clamp_ypos", int'(o_YPos), 430);
    check("bottom_clamp_fast", int'(o_Fast), 1);

    // Randomized frames with sticky direction so fast runs occur.
    ru = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 15);
      if (r >= 11) begin
        ru = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end
      ren = ($urandom_range(0, 7) != 0);
      run_frame(2, 4, ru, rd, ren, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
